// File: rtl/mem_arbiter.sv
// Shares NUM_CHANNELS memory read/write channels among NUM_CONSUMERS load/store units.
// Each channel claims one consumer in round-robin order, runs a single memory transaction, and relays the result back.
module mem_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]            consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]            consumer_write_ready,
    output logic [NUM_CHANNELS-1:0]             mem_read_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_read_address,
    input  logic [NUM_CHANNELS-1:0]             mem_read_ready,
    input  logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_read_data,
    output logic [NUM_CHANNELS-1:0]             mem_write_valid,
    output logic [NUM_CHANNELS*ADDR_BITS-1:0]   mem_write_address,
    output logic [NUM_CHANNELS*DATA_BITS-1:0]   mem_write_data,
    input  logic [NUM_CHANNELS-1:0]             mem_write_ready
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    // Handshake: a consumer holds valid until it sees ready; ready stays high until valid drops.
    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RELAY} state_t;

    state_t                 state_q    [NUM_CHANNELS];
    state_t                 state_d    [NUM_CHANNELS];
    logic [PTR_W-1:0]       owner_q    [NUM_CHANNELS];
    logic [PTR_W-1:0]       claim_idx  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0] op_read_q;
    logic [NUM_CHANNELS-1:0] claim;
    logic [NUM_CHANNELS-1:0] claim_read;
    logic [NUM_CHANNELS-1:0] release_ch;
    logic [PTR_W-1:0]       rr_ptr_q;
    logic [PTR_W-1:0]       rr_ptr_d;

    logic [ADDR_BITS-1:0]   c_raddr    [NUM_CONSUMERS];
    logic [ADDR_BITS-1:0]   c_waddr    [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   c_wdata    [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   crd_q      [NUM_CONSUMERS];
    logic [DATA_BITS-1:0]   m_rdata    [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   mra_q      [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]   mwa_q      [NUM_CHANNELS];
    logic [DATA_BITS-1:0]   mwd_q      [NUM_CHANNELS];

    for (genvar i = 0; i < NUM_CONSUMERS; i++) begin : g_cons
        assign c_raddr[i] = consumer_read_address[i*ADDR_BITS +: ADDR_BITS];
        assign c_waddr[i] = consumer_write_address[i*ADDR_BITS +: ADDR_BITS];
        assign c_wdata[i] = consumer_write_data[i*DATA_BITS +: DATA_BITS];
        assign consumer_read_data[i*DATA_BITS +: DATA_BITS] = crd_q[i];
    end

    for (genvar h = 0; h < NUM_CHANNELS; h++) begin : g_chan
        assign m_rdata[h] = mem_read_data[h*DATA_BITS +: DATA_BITS];
        assign mem_read_address[h*ADDR_BITS +: ADDR_BITS]  = mra_q[h];
        assign mem_write_address[h*ADDR_BITS +: ADDR_BITS] = mwa_q[h];
        assign mem_write_data[h*DATA_BITS +: DATA_BITS]    = mwd_q[h];
    end

    always_comb begin : claim_comb
        logic [NUM_CONSUMERS-1:0] taken;
        logic [PTR_W:0]           sum;
        logic [PTR_W-1:0]         idx;
        logic [PTR_W-1:0]         top_idx;
        logic                     any_claim;
        taken      = '0;
        sum        = '0;
        idx        = '0;
        top_idx    = '0;
        any_claim  = 1'b0;
        claim      = '0;
        claim_read = '0;
        release_ch = '0;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            claim_idx[ch] = '0;
            state_d[ch]   = state_q[ch];
            if (state_q[ch] != IDLE) taken[owner_q[ch]] = 1'b1;
        end
        // Lower channels pick first; each claim is marked taken so later channels skip it.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            if (state_q[ch] == IDLE) begin
                for (int k = 0; k < NUM_CONSUMERS; k++) begin
                    sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                    if (sum >= (PTR_W+1)'(NUM_CONSUMERS)) sum = sum - (PTR_W+1)'(NUM_CONSUMERS);
                    idx = sum[PTR_W-1:0];
                    if (!claim[ch] && !taken[idx] &&
                        (consumer_read_valid[idx] || consumer_write_valid[idx])) begin
                        claim[ch]      = 1'b1;
                        claim_read[ch] = consumer_read_valid[idx];
                        claim_idx[ch]  = idx;
                        taken[idx]     = 1'b1;
                        if (!any_claim || idx > top_idx) top_idx = idx;
                        any_claim = 1'b1;
                    end
                end
            end
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            case (state_q[ch])
                IDLE:       if (claim[ch]) state_d[ch] = claim_read[ch] ? READ_WAIT : WRITE_WAIT;
                READ_WAIT:  if (mem_read_ready[ch]) state_d[ch] = RELAY;
                WRITE_WAIT: if (mem_write_ready[ch]) state_d[ch] = RELAY;
                RELAY: begin
                    release_ch[ch] = op_read_q[ch] ? !consumer_read_valid[owner_q[ch]]
                                                   : !consumer_write_valid[owner_q[ch]];
                    if (release_ch[ch]) state_d[ch] = IDLE;
                end
                default:    state_d[ch] = IDLE;
            endcase
        end
        rr_ptr_d = rr_ptr_q;
        if (any_claim) rr_ptr_d = (top_idx == PTR_W'(NUM_CONSUMERS-1)) ? '0 : top_idx + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= IDLE;
            rr_ptr_q <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) state_q[ch] <= state_d[ch];
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_read_valid       <= '0;
            mem_write_valid      <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            op_read_q            <= '0;
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                owner_q[ch] <= '0;
                mra_q[ch]   <= '0;
                mwa_q[ch]   <= '0;
                mwd_q[ch]   <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) crd_q[c] <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                case (state_q[ch])
                    IDLE: begin
                        if (claim[ch]) begin
                            owner_q[ch]   <= claim_idx[ch];
                            op_read_q[ch] <= claim_read[ch];
                            if (claim_read[ch]) begin
                                mem_read_valid[ch] <= 1'b1;
                                mra_q[ch]          <= c_raddr[claim_idx[ch]];
                            end else begin
                                mem_write_valid[ch] <= 1'b1;
                                mwa_q[ch]           <= c_waddr[claim_idx[ch]];
                                mwd_q[ch]           <= c_wdata[claim_idx[ch]];
                            end
                        end
                    end
                    READ_WAIT: begin
                        if (mem_read_ready[ch]) begin
                            mem_read_valid[ch]           <= 1'b0;
                            consumer_read_ready[owner_q[ch]] <= 1'b1;
                            crd_q[owner_q[ch]]           <= m_rdata[ch];
                        end
                    end
                    WRITE_WAIT: begin
                        if (mem_write_ready[ch]) begin
                            mem_write_valid[ch]               <= 1'b0;
                            consumer_write_ready[owner_q[ch]] <= 1'b1;
                        end
                    end
                    RELAY: begin
                        // Read data stays in crd_q after ready drops.
                        if (release_ch[ch]) begin
                            if (op_read_q[ch]) consumer_read_ready[owner_q[ch]]  <= 1'b0;
                            else               consumer_write_ready[owner_q[ch]] <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized checks of mem_arbiter against a bench-side memory and per-consumer scoreboard.
// A second single-channel instance exercises round-robin fairness.
module tb_mem_arbiter;
  localparam int NC = 4;
  localparam int NH = 2;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [NC-1:0]    c_rv, c_wv, c_rr, c_wr;
  logic [NC*AW-1:0] c_ra, c_wa;
  logic [NC*DW-1:0] c_wd, c_rd;
  logic [NH-1:0]    m_rv, m_rr, m_wv, m_wr;
  logic [NH*AW-1:0] m_ra, m_wa;
  logic [NH*DW-1:0] m_rdata, m_wd;

  logic [NC-1:0]    f_rv, f_rr, f_wr;
  logic [NC*AW-1:0] f_ra;
  logic [NC*DW-1:0] f_rd;
  logic [0:0]       f_mrv, f_mrr, f_mwv, f_mwr;
  logic [AW-1:0]    f_mra, f_mwa;
  logic [DW-1:0]    f_mrd, f_mwd;

  mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(NH), .ADDR_BITS(AW), .DATA_BITS(DW)) u_dut (
    .clk(clk), .reset(reset),
    .consumer_read_valid(c_rv), .consumer_read_address(c_ra),
    .consumer_read_ready(c_rr), .consumer_read_data(c_rd),
    .consumer_write_valid(c_wv), .consumer_write_address(c_wa),
    .consumer_write_data(c_wd), .consumer_write_ready(c_wr),
    .mem_read_valid(m_rv), .mem_read_address(m_ra),
    .mem_read_ready(m_rr), .mem_read_data(m_rdata),
    .mem_write_valid(m_wv), .mem_write_address(m_wa),
    .mem_write_data(m_wd), .mem_write_ready(m_wr)
  );

  mem_arbiter #(.NUM_CONSUMERS(NC), .NUM_CHANNELS(1), .ADDR_BITS(AW), .DATA_BITS(DW)) u_fair (
    .clk(clk), .reset(reset),
    .consumer_read_valid(f_rv), .consumer_read_address(f_ra),
    .consumer_read_ready(f_rr), .consumer_read_data(f_rd),
    .consumer_write_valid({NC{1'b0}}), .consumer_write_address({NC*AW{1'b0}}),
    .consumer_write_data({NC*DW{1'b0}}), .consumer_write_ready(f_wr),
    .mem_read_valid(f_mrv), .mem_read_address(f_mra),
    .mem_read_ready(f_mrr), .mem_read_data(f_mrd),
    .mem_write_valid(f_mwv), .mem_write_address(f_mwa),
    .mem_write_data(f_mwd), .mem_write_ready(f_mwr)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem_model [256];
  logic [DW-1:0] ref_mem   [256];
  int rd_wait [NH];
  int wr_wait [NH];
  int rd_cnt  [NH];
  int wr_cnt  [NH];
  int mem_reads = 0;
  int mem_writes = 0;
  bit rand_mode = 1'b0;

  logic [11:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory responders: ready after rd_wait/wr_wait cycles of valid, one-cycle ready pulse.
  initial begin
    m_rr = '0; m_wr = '0; m_rdata = '0;
    f_mrr = '0; f_mwr = '0; f_mrd = '0;
    forever begin
      step();
      for (int ch = 0; ch < NH; ch++) begin
        if (m_rv[ch] && !m_rr[ch]) begin
          if (rd_cnt[ch] >= rd_wait[ch]) begin
            m_rr[ch] = 1'b1;
            m_rdata[ch*DW +: DW] = mem_model[m_ra[ch*AW +: AW]];
            rd_cnt[ch] = 0;
            mem_reads++;
            if (rand_mode) rd_wait[ch] = $urandom_range(0, 3);
          end else rd_cnt[ch]++;
        end else begin
          m_rr[ch] = 1'b0;
          if (!m_rv[ch]) rd_cnt[ch] = 0;
        end
        if (m_wv[ch] && !m_wr[ch]) begin
          if (wr_cnt[ch] >= wr_wait[ch]) begin
            m_wr[ch] = 1'b1;
            mem_model[m_wa[ch*AW +: AW]] = m_wd[ch*DW +: DW];
            wr_cnt[ch] = 0;
            mem_writes++;
            if (rand_mode) wr_wait[ch] = $urandom_range(0, 3);
          end else wr_cnt[ch]++;
        end else begin
          m_wr[ch] = 1'b0;
          if (!m_wv[ch]) wr_cnt[ch] = 0;
        end
      end
      if (f_mrv[0] && !f_mrr[0]) begin
        f_mrr[0] = 1'b1;
        f_mrd = {8'hA0, f_mra};
      end else f_mrr[0] = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Per-consumer state for the randomized phase
  int phase [NC];
  int gap   [NC];
  int hold  [NC];
  int tmo   [NC];
  bit is_rd [NC];
  logic [AW-1:0] r_addr [NC];
  logic [DW-1:0] r_wdat [NC];

  initial begin
    int lat, reads_before, grants, served3_at, pulses3, issued, done_ops, reads0, writes0;
    int pulses [NC];
    logic [NH-1:0] prev_mrv;
    logic [NC-1:0] prev_rr;
    logic [0:0] prev_f;
    logic [DW-1:0] v;

    reset = 1'b1;
    c_rv = '0; c_wv = '0; c_ra = '0; c_wa = '0; c_wd = '0;
    f_rv = '0; f_ra = '0;
    for (int ch = 0; ch < NH; ch++) begin
      rd_wait[ch] = 0; wr_wait[ch] = 0; rd_cnt[ch] = 0; wr_cnt[ch] = 0;
    end
    for (int a = 0; a < 256; a++) begin
      mem_model[a] = DW'(a * 3);
      ref_mem[a] = DW'(a * 3);
    end
    repeat (3) step();

    // Reset state
    check("rst_c_ready", {c_rr, c_wr}, 0);
    check("rst_m_valid", {m_rv, m_wv}, 0);
    check("rst_m_addr", {m_ra, m_wa}, 0);
    check("rst_m_wdata", m_wd, 0);
    check("rst_c_rdata", c_rd, 0);
    reset = 1'b0;

    // Single read with 3 memory wait cycles
    mem_model[8'h10] = 16'hBEEF;
    rd_wait[0] = 3; rd_wait[1] = 3;
    c_ra[2*AW +: AW] = 8'h10;
    c_rv[2] = 1'b1;
    step();
    lat = 1;
    check("t1_mrv", m_rv, 2'b01);
    check("t1_mra", m_ra[AW-1:0], 8'h10);
    check("t1_crr_early", c_rr, 0);
    while (!c_rr[2] && lat < 40) begin step(); lat++; end
    check("t1_latency", lat, 2 + 3);
    check("t1_crr", c_rr, 4'b0100);
    check("t1_crd", c_rd[2*DW +: DW], 16'hBEEF);
    c_rv[2] = 1'b0;
    step();
    check("t1_crr_clear", c_rr, 0);
    check("t1_crd_hold", c_rd[2*DW +: DW], 16'hBEEF);
    check("t1_mrv_idle", m_rv, 0);

    // Contention: all four consumers read together
    reset = 1'b1; step(); reset = 1'b0;
    rd_wait[0] = 1; rd_wait[1] = 1;
    for (int i = 0; i < NC; i++) begin
      mem_model[8'h40 + i] = 16'h5A00 + 16'(i);
      c_ra[i*AW +: AW] = 8'(8'h40 + i);
      pulses[i] = 0;
    end
    exp_q.push_back({4'd0, 8'h40});
    exp_q.push_back({4'd1, 8'h41});
    exp_q.push_back({4'd0, 8'h42});
    exp_q.push_back({4'd1, 8'h43});
    c_rv = 4'hF;
    prev_mrv = '0; prev_rr = '0;
    repeat (24) begin
      step();
      for (int ch = 0; ch < NH; ch++) begin
        if (m_rv[ch] && !prev_mrv[ch]) begin
          if (exp_q.size() == 0) check("t2_extra_grant", {4'(ch), m_ra[ch*AW +: AW]}, 12'h0);
          else check("t2_grant", {4'(ch), m_ra[ch*AW +: AW]}, exp_q.pop_front());
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (c_rr[c] && !prev_rr[c]) begin
          pulses[c]++;
          check("t2_data", c_rd[c*DW +: DW], 16'h5A00 + 16'(c));
        end
        if (c_rr[c]) c_rv[c] = 1'b0;
      end
      prev_mrv = m_rv;
      prev_rr = c_rr;
    end
    for (int c = 0; c < NC; c++) check("t2_pulses", pulses[c], 1);
    check("t2_grants_left", exp_q.size(), 0);

    // Write from consumer 1
    wr_wait[0] = 2; wr_wait[1] = 2;
    c_wa[1*AW +: AW] = 8'h20;
    c_wd[1*DW +: DW] = 16'h1234;
    c_wv[1] = 1'b1;
    step();
    lat = 1;
    check("t3_mwv", m_wv, 2'b01);
    check("t3_mwa", m_wa[AW-1:0], 8'h20);
    check("t3_mwd", m_wd[DW-1:0], 16'h1234);
    check("t3_mrv", m_rv, 0);
    while (!c_wr[1] && lat < 40) begin step(); lat++; end
    check("t3_latency", lat, 2 + 2);
    check("t3_cwr", c_wr, 4'b0010);
    check("t3_crr", c_rr, 0);
    check("t3_mem", mem_model[8'h20], 16'h1234);
    c_wv[1] = 1'b0;
    step();
    check("t3_cwr_clear", c_wr, 0);

    // Ready held while valid stays high; no second memory request
    rd_wait[0] = 0; rd_wait[1] = 0;
    mem_model[8'h33] = 16'h0C0F;
    c_ra[0 +: AW] = 8'h33;
    c_rv[0] = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!c_rr[0] && lat < 40);
    check("t4_latency", lat, 2);
    check("t4_crd", c_rd[DW-1:0], 16'h0C0F);
    reads_before = mem_reads;
    repeat (5) begin
      step();
      check("t4_hold", c_rr, 4'b0001);
      check("t4_no_mrv", m_rv, 0);
    end
    check("t4_no_reissue", mem_reads, reads_before);
    c_rv[0] = 1'b0;
    step();
    check("t4_clear", c_rr, 0);

    // Reset asserted while a channel waits on memory
    rd_wait[0] = 10; rd_wait[1] = 10;
    c_ra[3*AW +: AW] = 8'h7E;
    c_rv[3] = 1'b1;
    step();
    step();
    check("t5_pending", |m_rv, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("t5_ready", {c_rr, c_wr}, 0);
    check("t5_valid", {m_rv, m_wv}, 0);
    check("t5_addr", {m_ra, m_wa}, 0);
    check("t5_data", {m_wd, c_rd}, 0);
    c_rv[3] = 1'b0;
    #2 reset = 1'b0;
    rd_wait[0] = 0; rd_wait[1] = 0;
    mem_model[8'h7E] = 16'h7777;
    step();
    c_rv[3] = 1'b1;
    lat = 0;
    do begin step(); lat++; end while (!c_rr[3] && lat < 40);
    check("t5_after_latency", lat, 2);
    check("t5_after_data", c_rd[3*DW +: DW], 16'h7777);
    c_rv[3] = 1'b0;
    step();

    // Fairness with one channel: consumer 0 hammers, consumer 3 asks once
    f_ra[0 +: AW] = 8'h00;
    f_ra[3*AW +: AW] = 8'h30;
    f_rv[0] = 1'b1; f_rv[3] = 1'b1;
    grants = 0; served3_at = 0; pulses3 = 0; prev_f = '0;
    repeat (40) begin
      step();
      if (f_mrv[0] && !prev_f[0]) begin
        grants++;
        if (f_mra == 8'h30 && served3_at == 0) served3_at = grants;
      end
      prev_f = f_mrv;
      if (f_rr[3]) begin
        pulses3++;
        check("t6_c3_data", f_rd[3*DW +: DW], 16'hA030);
        f_rv[3] = 1'b0;
      end
      if (f_rr[0]) f_rv[0] = 1'b0;
      else if (!f_rv[0]) f_rv[0] = 1'b1;
    end
    check("t6_c3_within_4", (served3_at >= 1) && (served3_at <= 4), 1'b1);
    check("t6_c3_once", pulses3, 1);
    check("t6_c0_progress", grants >= 8, 1'b1);
    check("t6_no_write", {f_wr, f_mwv, f_mwa, f_mwd}, 0);
    f_rv = '0;

    // Randomized traffic: private address region per consumer, random memory latency
    for (int a = 0; a < 256; a++) begin
      v = DW'($urandom);
      mem_model[a] = v;
      ref_mem[a] = v;
    end
    rand_mode = 1'b1;
    for (int ch = 0; ch < NH; ch++) begin
      rd_wait[ch] = $urandom_range(0, 3);
      wr_wait[ch] = $urandom_range(0, 3);
    end
    for (int c = 0; c < NC; c++) begin
      phase[c] = 0; gap[c] = $urandom_range(0, 3); hold[c] = 0; tmo[c] = 0;
    end
    issued = 0; done_ops = 0; reads0 = mem_reads; writes0 = mem_writes;
    for (int cyc = 0; cyc < 700; cyc++) begin
      step();
      for (int c = 0; c < NC; c++) begin
        case (phase[c])
          0: begin
            check("t7_idle_ready", {c_rr[c], c_wr[c]}, 2'b00);
            if (cyc < 500) begin
              if (gap[c] == 0) begin
                is_rd[c] = 1'($urandom_range(0, 1));
                r_addr[c] = 8'(c * 64 + $urandom_range(0, 63));
                if (is_rd[c]) begin
                  c_ra[c*AW +: AW] = r_addr[c];
                  c_rv[c] = 1'b1;
                end else begin
                  r_wdat[c] = DW'($urandom);
                  c_wa[c*AW +: AW] = r_addr[c];
                  c_wd[c*DW +: DW] = r_wdat[c];
                  c_wv[c] = 1'b1;
                end
                issued++;
                tmo[c] = 0;
                phase[c] = 1;
              end else gap[c]--;
            end
          end
          1: begin
            if (is_rd[c] ? c_rr[c] : c_wr[c]) begin
              if (is_rd[c]) check("t7_rdata", c_rd[c*DW +: DW], ref_mem[r_addr[c]]);
              else ref_mem[r_addr[c]] = r_wdat[c];
              check("t7_other_ready", is_rd[c] ? c_wr[c] : c_rr[c], 1'b0);
              done_ops++;
              hold[c] = $urandom_range(0, 2);
              phase[c] = 2;
              if (hold[c] == 0) begin
                c_rv[c] = 1'b0; c_wv[c] = 1'b0;
                gap[c] = $urandom_range(0, 3);
                phase[c] = 0;
              end
            end else begin
              tmo[c]++;
              if (tmo[c] > 60) begin
                check("t7_timeout", is_rd[c] ? c_rr[c] : c_wr[c], 1'b1);
                c_rv[c] = 1'b0; c_wv[c] = 1'b0;
                phase[c] = 0;
              end
            end
          end
          default: begin
            check("t7_hold", is_rd[c] ? c_rr[c] : c_wr[c], 1'b1);
            hold[c]--;
            if (hold[c] <= 0) begin
              c_rv[c] = 1'b0; c_wv[c] = 1'b0;
              gap[c] = $urandom_range(0, 3);
              phase[c] = 0;
            end
          end
        endcase
      end
    end
    check("t7_all_done", done_ops, issued);
    check("t7_mem_txns", (mem_reads - reads0) + (mem_writes - writes0), issued);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_CONSUMERS, default 4, the number of LSUs sharing data memory.
REQ-002 The block SHALL have parameter NUM_CHANNELS, default 2, the number of concurrent memory channels.
REQ-003 The block SHALL have parameter ADDR_BITS, default 8, the data memory address width.
REQ-004 The block SHALL have parameter DATA_BITS, default 16, the data memory word width.
REQ-005 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Ports consumer_read_valid, input, NUM_CONSUMERS, and consumer_read_address, input, NUM_CONSUMERS x ADDR_BITS: per-LSU read request.
REQ-008 Ports consumer_read_ready, output, NUM_CONSUMERS, and consumer_read_data, output, NUM_CONSUMERS x DATA_BITS: per-LSU read completion.
REQ-009 Ports consumer_write_valid, input, NUM_CONSUMERS; consumer_write_address, input, NUM_CONSUMERS x ADDR_BITS; consumer_write_data, input, NUM_CONSUMERS x DATA_BITS: per-LSU write request.
REQ-010 Port consumer_write_ready, output, NUM_CONSUMERS: per-LSU write completion.
REQ-011 Ports mem_read_valid, output, NUM_CHANNELS; mem_read_address, output, NUM_CHANNELS x ADDR_BITS; mem_read_ready, input, NUM_CHANNELS; mem_read_data, input, NUM_CHANNELS x DATA_BITS: memory read channels.
REQ-012 Ports mem_write_valid, output, NUM_CHANNELS; mem_write_address, output, NUM_CHANNELS x ADDR_BITS; mem_write_data, output, NUM_CHANNELS x DATA_BITS; mem_write_ready, input, NUM_CHANNELS: memory write channels.

Function
REQ-013 Each channel SHALL run an FSM with states IDLE, READ_WAIT, WRITE_WAIT, RELAY.
REQ-014 In IDLE, a channel SHALL claim the first unclaimed consumer with read_valid or write_valid set, searching round-robin from rr_ptr; read takes priority over write for the same consumer.
REQ-015 Channels SHALL choose in ascending channel index within a cycle; no consumer is claimed by two channels; each channel claims at most one consumer.
REQ-016 On a read claim the channel SHALL register mem_read_valid=1 and mem_read_address=consumer address next edge, entering READ_WAIT; on a write claim it SHALL register mem_write_valid/address/data and enter WRITE_WAIT.
REQ-017 In READ_WAIT with mem_read_ready=1, the channel SHALL clear mem_read_valid, drive consumer_read_ready=1 and consumer_read_data=mem_read_data next edge, and enter RELAY.
REQ-018 In WRITE_WAIT with mem_write_ready=1, the channel SHALL clear mem_write_valid, drive consumer_write_ready=1 next edge, and enter RELAY.
REQ-019 In RELAY, the channel SHALL hold consumer ready high until the consumer drops its matching valid, then clear ready, release the claim, and return to IDLE on that edge.
REQ-020 consumer_read_data SHALL hold its last value after ready clears.
REQ-021 rr_ptr SHALL advance to (highest consumer index claimed this cycle + 1) mod NUM_CONSUMERS; unchanged if no claim.
REQ-022 Minimum read latency, consumer valid to consumer ready, SHALL be 2 cycles plus the memory wait cycles.
REQ-023 A consumer valid that drops while its channel is in READ_WAIT/WRITE_WAIT SHALL NOT abort the memory transaction.
REQ-024 Unclaimed consumers SHALL see ready=0.

Reset
REQ-025 Reset SHALL asynchronously force all channels to IDLE, clear all claims, set rr_ptr=0, and zero every output (valid, ready, address, data), including mid-transaction.

Verification
REQ-026 Single read: consumer 2 read addr 0x10, mem returns 0xBEEF after 3 cycles -> ch0 mem_read_address=0x10, consumer_read_ready[2]=1 with data 0xBEEF, ch0 IDLE after valid drops.
REQ-027 Contention: consumers 0-3 read at once, mem ready after 1 cycle -> ch0 serves 0, ch1 serves 1, then 2 and 3; every consumer gets exactly one ready pulse.
REQ-028 Write: consumer 1 writes 0x1234 to 0x20 -> mem_write_address=0x20, mem_write_data=0x1234, consumer_write_ready[1]=1 after mem_write_ready.
REQ-029 Fairness: consumer 0 re-requests continuously, consumer 3 once, NUM_CHANNELS=1 -> consumer 3 served within 4 grants.
REQ-030 Reset asserted in READ_WAIT -> all outputs 0 immediately (no clock edge); new request afterwards served normally.
REQ-031 Ready hold: consumer keeps valid 5 cycles after ready -> ready held 5 cycles, no second memory request issued.
